enemy_attack_sequencer: RTL and testbench

Pacing and combat stage wrapped around the enemy position FSM. It generates the enemy step strobe and the random direction bit (`go`), and tracks enemy health from player punches. It consumes the FSM's `x_pos`, `speed`, `attack` and `dead` outputs to schedule windup/strike/recover attack cycles and to decide player damage. It feeds `health`, `go` and `step` back to the enemy FSM and exposes combat status to the VGA/draw path.

---
 rtl/enemy_pkg.sv | 35 +++
 rtl/enemy_rate_divider.sv | 34 +++
 rtl/enemy_attack_sequencer.sv | 160 ++++++++++++++++
 tb/tb_enemy_attack_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared encodings for the enemy pacing/combat stage: FSM states, position codes,
// attack thresholds, LFSR seed and small arithmetic helpers.
`default_nettype none

package enemy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WINDUP  = 3'd1,
      ST_STRIKE  = 3'd2,
      ST_RECOVER = 3'd3,
      ST_KO      = 3'd4
   } state_t;

   localparam logic [1:0] POS_LEFT  = 2'd1;
   localparam logic [1:0] POS_MID   = 2'd2;
   localparam logic [1:0] POS_RIGHT = 2'd3;

   localparam logic [2:0] CALM_THRESH = 3'd4;
   localparam logic [2:0] AGGR_THRESH = 3'd2;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Fibonacci LFSR, taps 8,6,5,4.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [3:0] sat_sub(input logic [3:0] h, input logic [3:0] d);
      return (h > d) ? (h - d) : 4'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_rate_divider.sv
// Step-rate down-counter: ticks when it reaches zero, then reloads the calm or the
// aggressive period depending on speed_i sampled at that reload.
`default_nettype none

module enemy_rate_divider #(
   parameter int BASE_DIV = 25000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic speed_i,
   output logic tick_o
);

   localparam int CW = $clog2(BASE_DIV);
   localparam logic [CW-1:0] CALM_RELOAD = CW'(BASE_DIV - 1);
   localparam logic [CW-1:0] AGGR_RELOAD = CW'(BASE_DIV / 2 - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] reload_d;

   assign reload_d = speed_i ? AGGR_RELOAD : CALM_RELOAD;
   assign tick_o   = (cnt_q == '0);

   always_ff @(posedge clock) begin
      if (!reset_n || tick_o) begin
         cnt_q <= reload_d;
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/enemy_attack_sequencer.sv
// Enemy pacing and windup/strike/recover combat sequencer around the enemy position FSM.
// Optional ENEMY_SEQ_FEINT_EN: a windup may end in a feint back to IDLE instead of a strike.
`default_nettype none

module enemy_attack_sequencer
   import enemy_pkg::*;
#(
   parameter int BASE_DIV      = 25000000,
   parameter int WINDUP_TICKS  = 2,
   parameter int RECOVER_TICKS = 2,
   parameter int HEALTH_INIT   = 10
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] x_pos,
   input  logic       speed,
   input  logic       attack,
   input  logic       dead,
   input  logic       player_block,
   input  logic       player_dodge,
   input  logic       player_punch,
   output logic       step,
   output logic       go,
   output logic [3:0] health,
   output logic       telegraph,
   output logic [1:0] strike_x,
   output logic       player_hit,
   output logic       vulnerable,
   output logic       ko
);

   localparam logic [3:0] WIN_LAST = 4'(WINDUP_TICKS - 1);
   localparam logic [3:0] REC_LAST = 4'(RECOVER_TICKS - 1);
   localparam logic [3:0] H_INIT   = 4'(HEALTH_INIT);

   logic       tick;
   state_t     state_q;
   logic [2:0] move_cnt_q;
   logic [3:0] phase_q;
   logic [7:0] lfsr_q;
   logic [3:0] health_q, health_d;
   logic       step_q, go_q, telegraph_q, vulnerable_q, hit_q, ko_q;
   logic [1:0] strike_x_q;
   logic [2:0] thresh;

   enemy_rate_divider #(.BASE_DIV(BASE_DIV)) u_div (
      .clock   (clock),
      .reset_n (reset_n),
      .speed_i (speed),
      .tick_o  (tick)
   );

   assign thresh = attack ? AGGR_THRESH : CALM_THRESH;

   // Punches land for 1 in IDLE, 2 while vulnerable, and are guarded otherwise.
   always_comb begin
      health_d = health_q;
      if (player_punch) begin
         case (state_q)
            ST_IDLE:    health_d = sat_sub(health_q, 4'd1);
            ST_RECOVER: health_d = sat_sub(health_q, 4'd2);
            default:    health_d = health_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         move_cnt_q   <= '0;
         phase_q      <= '0;
         lfsr_q       <= LFSR_SEED;
         health_q     <= H_INIT;
         step_q       <= 1'b0;
         go_q         <= 1'b0;
         telegraph_q  <= 1'b0;
         vulnerable_q <= 1'b0;
         hit_q        <= 1'b0;
         ko_q         <= 1'b0;
         strike_x_q   <= '0;
      end else begin
         step_q   <= 1'b0;
         hit_q    <= 1'b0;
         health_q <= health_d;
         if (tick) begin
            lfsr_q <= lfsr_next(lfsr_q);
         end
         if (state_q == ST_KO || health_q == 4'd0 || dead) begin
            state_q      <= ST_KO;
            ko_q         <= 1'b1;
            telegraph_q  <= 1'b0;
            vulnerable_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (tick) begin
                     step_q <= 1'b1;
                     go_q   <= lfsr_q[0];
                     if (move_cnt_q + 3'd1 == thresh) begin
                        state_q     <= ST_WINDUP;
                        move_cnt_q  <= '0;
                        phase_q     <= '0;
                        strike_x_q  <= x_pos;
                        telegraph_q <= 1'b1;
                     end else begin
                        move_cnt_q <= move_cnt_q + 3'd1;
                     end
                  end
               end
               ST_WINDUP: begin
                  if (tick && phase_q == WIN_LAST) begin
                     phase_q     <= '0;
                     telegraph_q <= 1'b0;
`ifdef ENEMY_SEQ_FEINT_EN
                     if (lfsr_q[1:0] == 2'b11) begin
                        state_q    <= ST_IDLE;
                        move_cnt_q <= '0;
                     end else begin
                        state_q <= ST_STRIKE;
                     end
`else
                     state_q <= ST_STRIKE;
`endif
                  end else if (tick) begin
                     phase_q <= phase_q + 4'd1;
                  end
               end
               ST_STRIKE: begin
                  hit_q        <= !player_block && !player_dodge;
                  state_q      <= ST_RECOVER;
                  phase_q      <= '0;
                  vulnerable_q <= 1'b1;
               end
               ST_RECOVER: begin
                  if (tick && phase_q == REC_LAST) begin
                     phase_q      <= '0;
                     state_q      <= ST_IDLE;
                     vulnerable_q <= 1'b0;
                  end else if (tick) begin
                     phase_q <= phase_q + 4'd1;
                  end
               end
               default: state_q <= ST_KO;
            endcase
         end
      end
   end

   assign step       = step_q;
   assign go         = go_q;
   assign health     = health_q;
   assign telegraph  = telegraph_q;
   assign strike_x   = strike_x_q;
   assign player_hit = hit_q;
   assign vulnerable = vulnerable_q;
   assign ko         = ko_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_attack_sequencer.sv
// Self-checking bench for enemy_attack_sequencer with BASE_DIV=8 (calm tick every 8
// cycles, aggressive every 4); expected events are queued and popped as they occur.
`default_nettype none

module tb_enemy_attack_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [1:0] x_pos;
   logic       speed, attack, dead;
   logic       player_block, player_dodge, player_punch;
   logic       step, go, telegraph, player_hit, vulnerable, ko;
   logic [3:0] health;
   logic [1:0] strike_x;

   typedef struct {
      int         cyc;
      logic [3:0] val;
   } exp_t;

   exp_t sq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   enemy_attack_sequencer #(
      .BASE_DIV(8), .WINDUP_TICKS(2), .RECOVER_TICKS(2), .HEALTH_INIT(10)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .x_pos        (x_pos),
      .speed        (speed),
      .attack       (attack),
      .dead         (dead),
      .player_block (player_block),
      .player_dodge (player_dodge),
      .player_punch (player_punch),
      .step         (step),
      .go           (go),
      .health       (health),
      .telegraph    (telegraph),
      .strike_x     (strike_x),
      .player_hit   (player_hit),
      .vulnerable   (vulnerable),
      .ko           (ko)
   );

   always #5 clock = ~clock;

   // cyc numbers the cycle whose outputs are visible at this negedge; cyc=1 right after release.
   task automatic step_clk();
      @(negedge clock);
      cyc++;
   endtask

   task automatic do_reset(input logic spd, input logic atk, input logic [1:0] xp);
      speed = spd; attack = atk; x_pos = xp; dead = 1'b0;
      player_block = 1'b0; player_dodge = 1'b0; player_punch = 1'b0;
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      cyc = 1;
      sq.delete();
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0, 2'd2);
      tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b, expected 0", step); end
      tests++; if (go !== 1'b0) begin fails++; $display("FAIL reset_go: got %b, expected 0", go); end
      tests++; if (health !== 4'd10) begin fails++; $display("FAIL reset_health: got %0d, expected 10", health); end
      tests++; if (telegraph !== 1'b0) begin fails++; $display("FAIL reset_telegraph: got %b, expected 0", telegraph); end
      tests++; if (strike_x !== 2'd0) begin fails++; $display("FAIL reset_strike_x: got %0d, expected 0", strike_x); end
      tests++; if (player_hit !== 1'b0 || vulnerable !== 1'b0 || ko !== 1'b0) begin
         fails++; $display("FAIL reset_status: got hit=%b vul=%b ko=%b, expected 0 0 0", player_hit, vulnerable, ko);
      end
   endtask

   task automatic test_calm_sequence();
      int tel_rise = -1, tel_n = 0, hit_n = 0, hit_cyc = -1, vul_rise = -1, vul_n = 0;
      exp_t e;
      do_reset(1'b0, 1'b0, 2'd2);
      sq.push_back('{9, 4'd1}); sq.push_back('{17, 4'd0});
      sq.push_back('{25, 4'd1}); sq.push_back('{33, 4'd0});
      for (int i = 0; i < 69; i++) begin
         step_clk();
         if (step) begin
            tests++;
            if (sq.size() == 0) begin
               fails++; $display("FAIL calm_step: got step at cycle %0d, expected none", cyc);
            end else begin
               e = sq.pop_front();
               if (cyc !== e.cyc || go !== e.val[0]) begin
                  fails++;
                  $display("FAIL calm_step: got cycle %0d go %b, expected cycle %0d go %b", cyc, go, e.cyc, e.val[0]);
               end
            end
         end
         if (telegraph) begin tel_n++; if (tel_rise < 0) tel_rise = cyc; end
         if (player_hit) begin hit_n++; hit_cyc = cyc; end
         if (vulnerable) begin vul_n++; if (vul_rise < 0) vul_rise = cyc; end
      end
      tests++; if (sq.size() != 0) begin fails++; $display("FAIL calm_missing_steps: got %0d left, expected 0", sq.size()); end
      tests++; if (tel_rise != 33 || tel_n != 16) begin
         fails++; $display("FAIL calm_telegraph: got rise %0d len %0d, expected rise 33 len 16", tel_rise, tel_n);
      end
      tests++; if (hit_n != 1 || hit_cyc != 50) begin
         fails++; $display("FAIL calm_hit: got %0d pulses at %0d, expected 1 at 50", hit_n, hit_cyc);
      end
      // RECOVER spans from the cycle after STRIKE up to the second recover tick at cycle 64.
      tests++; if (vul_rise != 50 || vul_n != 15) begin
         fails++; $display("FAIL calm_vulnerable: got rise %0d len %0d, expected rise 50 len 15", vul_rise, vul_n);
      end
      tests++; if (strike_x !== 2'd2) begin fails++; $display("FAIL calm_strike_x: got %0d, expected 2", strike_x); end
      tests++; if (health !== 4'd10) begin fails++; $display("FAIL calm_health: got %0d, expected 10", health); end
   endtask

   task automatic test_aggressive();
      int tel_rise = -1;
      exp_t e;
      do_reset(1'b1, 1'b1, 2'd3);
      sq.push_back('{5, 4'd1}); sq.push_back('{9, 4'd0});
      for (int i = 0; i < 16; i++) begin
         step_clk();
         if (cyc == 10) x_pos = 2'd1;
         if (step) begin
            tests++;
            if (sq.size() == 0) begin
               fails++; $display("FAIL aggr_step: got step at cycle %0d, expected none", cyc);
            end else begin
               e = sq.pop_front();
               if (cyc !== e.cyc || go !== e.val[0]) begin
                  fails++;
                  $display("FAIL aggr_step: got cycle %0d go %b, expected cycle %0d go %b", cyc, go, e.cyc, e.val[0]);
               end
            end
         end
         if (telegraph && tel_rise < 0) tel_rise = cyc;
      end
      tests++; if (sq.size() != 0) begin fails++; $display("FAIL aggr_missing_steps: got %0d left, expected 0", sq.size()); end
      tests++; if (tel_rise != 9) begin fails++; $display("FAIL aggr_windup: got rise %0d, expected 9", tel_rise); end
      tests++; if (strike_x !== 2'd3) begin fails++; $display("FAIL aggr_strike_x: got %0d, expected 3", strike_x); end
   endtask

   task automatic test_guard(input logic blk, input logic dge);
      int hit_n = 0, vul_rise = -1, vul_n = 0;
      exp_t e;
      do_reset(1'b1, 1'b1, 2'd2);
      player_block = blk; player_dodge = dge;
      sq.push_back('{5, 4'd1}); sq.push_back('{9, 4'd0}); sq.push_back('{29, 4'd1});
      for (int i = 0; i < 29; i++) begin
         step_clk();
         if (step) begin
            tests++;
            if (sq.size() == 0) begin
               fails++; $display("FAIL guard_step: got step at cycle %0d, expected none", cyc);
            end else begin
               e = sq.pop_front();
               if (cyc !== e.cyc || go !== e.val[0]) begin
                  fails++;
                  $display("FAIL guard_step: got cycle %0d go %b, expected cycle %0d go %b", cyc, go, e.cyc, e.val[0]);
               end
            end
         end
         if (player_hit) hit_n++;
         if (vulnerable) begin vul_n++; if (vul_rise < 0) vul_rise = cyc; end
      end
      tests++; if (hit_n != 0) begin fails++; $display("FAIL guard_hit: got %0d pulses, expected 0 (blk=%b dge=%b)", hit_n, blk, dge); end
      tests++; if (vul_rise != 18 || vul_n != 7) begin
         fails++; $display("FAIL guard_recover: got rise %0d len %0d, expected rise 18 len 7", vul_rise, vul_n);
      end
      tests++; if (sq.size() != 0) begin fails++; $display("FAIL guard_idle_return: got %0d steps left, expected 0", sq.size()); end
      player_block = 1'b0; player_dodge = 1'b0;
   endtask

   task automatic test_health();
      exp_t e;
      do_reset(1'b1, 1'b1, 2'd2);
      // Punches in IDLE, IDLE, WINDUP, STRIKE, RECOVER.
      sq.push_back('{3, 4'd9});  sq.push_back('{5, 4'd8});
      sq.push_back('{13, 4'd8}); sq.push_back('{18, 4'd8}); sq.push_back('{21, 4'd6});
      for (int i = 0; i < 23; i++) begin
         step_clk();
         if (sq.size() != 0 && sq[0].cyc == cyc) begin
            e = sq.pop_front();
            tests++;
            if (health !== e.val) begin
               fails++; $display("FAIL health_punch: got %0d at cycle %0d, expected %0d", health, cyc, e.val);
            end
         end
         player_punch = (cyc == 2 || cyc == 4 || cyc == 12 || cyc == 17 || cyc == 20);
      end
      player_punch = 1'b0;
      tests++; if (sq.size() != 0) begin fails++; $display("FAIL health_pending: got %0d left, expected 0", sq.size()); end
   endtask

   task automatic test_ko();
      int late_steps = 0;
      exp_t e;
      do_reset(1'b0, 1'b0, 2'd1);
      sq.push_back('{11, 4'd1}); sq.push_back('{53, 4'd0}); sq.push_back('{54, 4'd0});
      for (int i = 0; i < 94; i++) begin
         step_clk();
         if (sq.size() != 0 && sq[0].cyc == cyc) begin
            e = sq.pop_front();
            tests++;
            if (health !== e.val) begin
               fails++; $display("FAIL ko_health: got %0d at cycle %0d, expected %0d", health, cyc, e.val);
            end
         end
         if (cyc == 53) begin
            tests++; if (ko !== 1'b0) begin fails++; $display("FAIL ko_early: got %b at 53, expected 0", ko); end
         end
         if (cyc == 54) begin
            tests++; if (ko !== 1'b1 || vulnerable !== 1'b0) begin
               fails++; $display("FAIL ko_entry: got ko=%b vul=%b at 54, expected 1 0", ko, vulnerable);
            end
         end
         if (cyc > 54 && step) late_steps++;
         player_punch = (cyc >= 2 && cyc <= 10) || cyc == 52 || cyc == 53;
      end
      player_punch = 1'b0;
      tests++; if (late_steps != 0 || ko !== 1'b1) begin
         fails++; $display("FAIL ko_absorb: got %0d steps ko=%b, expected 0 steps ko=1", late_steps, ko);
      end
      reset_n = 1'b0;
      step_clk();
      reset_n = 1'b1;
      cyc = 1;
      tests++; if (health !== 4'd10 || ko !== 1'b0) begin
         fails++; $display("FAIL ko_reset: got health=%0d ko=%b, expected 10 0", health, ko);
      end
      for (int i = 0; i < 8; i++) step_clk();
      tests++; if (step !== 1'b1) begin fails++; $display("FAIL ko_reset_idle: got step=%b at 9, expected 1", step); end
   endtask

   task automatic test_dead();
      int steps_n = 0;
      do_reset(1'b1, 1'b1, 2'd2);
      step_clk();
      dead = 1'b1;
      step_clk();
      dead = 1'b0;
      tests++; if (ko !== 1'b1) begin fails++; $display("FAIL dead_ko: got %b at cycle %0d, expected 1", ko, cyc); end
      for (int i = 0; i < 12; i++) begin
         step_clk();
         if (step || telegraph) steps_n++;
      end
      tests++; if (steps_n != 0 || ko !== 1'b1) begin
         fails++; $display("FAIL dead_absorb: got %0d active cycles ko=%b, expected 0 1", steps_n, ko);
      end
   endtask

   task automatic test_reset_mid_attack();
      do_reset(1'b1, 1'b1, 2'd3);
      for (int i = 0; i < 16; i++) step_clk();
      reset_n = 1'b0;
      step_clk();
      tests++; if (player_hit !== 1'b0 || vulnerable !== 1'b0 || telegraph !== 1'b0) begin
         fails++; $display("FAIL midreset_status: got hit=%b vul=%b tel=%b, expected 0 0 0", player_hit, vulnerable, telegraph);
      end
      tests++; if (strike_x !== 2'd0 || health !== 4'd10) begin
         fails++; $display("FAIL midreset_regs: got strike_x=%0d health=%0d, expected 0 10", strike_x, health);
      end
      reset_n = 1'b1;
      cyc = 1;
      for (int i = 0; i < 4; i++) step_clk();
      tests++; if (step !== 1'b1 || player_hit !== 1'b0) begin
         fails++; $display("FAIL midreset_restart: got step=%b hit=%b at 5, expected 1 0", step, player_hit);
      end
   endtask

   initial begin
      reset_n = 1'b0; x_pos = 2'd2; speed = 1'b0; attack = 1'b0; dead = 1'b0;
      player_block = 1'b0; player_dodge = 1'b0; player_punch = 1'b0;
      test_reset();
      test_calm_sequence();
      test_aggressive();
      test_guard(1'b1, 1'b0);
      test_guard(1'b0, 1'b1);
      test_health();
      test_ko();
      test_dead();
      test_reset_mid_attack();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
